// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Rotates exist only when SHIFTER_ROTATE_EN is defined.
package shifter_pkg;

    localparam int SHIFT_OP_WIDTH = 3;
    localparam int MAX_WIDTH      = 64;

    typedef enum logic [SHIFT_OP_WIDTH-1:0] {
        SHIFT_SLL = 3'b000,
        SHIFT_SRL = 3'b001,
        SHIFT_SRA = 3'b011,
        SHIFT_ROL = 3'b100,
        SHIFT_ROR = 3'b101
    } shift_op_e;

    // Reverses the low w bits; bits at and above w read as zero.
    function automatic logic [MAX_WIDTH-1:0] bit_reverse(
        input logic [MAX_WIDTH-1:0] d,
        input int                   w
    );
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < w) r[i] = d[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/pipelined_shifter_stage.sv
// One pipeline stage: a run of shift levels followed by a register.
// The wrap mux is built only when SHIFTER_ROTATE_EN is defined.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int FIRST_LEVEL = 0,
    parameter int NUM_LEVELS  = 1,
    parameter int TAG_WIDTH   = 5,
    parameter int AMT_WIDTH   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [AMT_WIDTH-1:0] in_amount,
    input  logic                 in_right,
    input  logic                 in_rot,
    input  logic                 in_fill,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [AMT_WIDTH-1:0] out_amount,
    output logic                 out_right,
    output logic                 out_rot,
    output logic                 out_fill,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int L = $clog2(WIDTH);

    logic             advance;
    logic [WIDTH-1:0] shifted;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Level k shifts by 2^(L-1-k); fill enters at the LSB side.
    always_comb begin
        shifted = in_data;
        for (int j = 0; j < NUM_LEVELS; j++) begin
            if (in_amount[L-1-FIRST_LEVEL-j]) begin
`ifdef SHIFTER_ROTATE_EN
                if (in_rot)
                    shifted = (shifted << (1 << (L-1-FIRST_LEVEL-j)))
                            | (shifted >> (WIDTH - (1 << (L-1-FIRST_LEVEL-j))));
                else
`endif
                    shifted = (shifted << (1 << (L-1-FIRST_LEVEL-j)))
                            | ({WIDTH{in_fill}}
                               & ~({WIDTH{1'b1}} << (1 << (L-1-FIRST_LEVEL-j))));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_amount <= '0;
            out_right  <= 1'b0;
            out_rot    <= 1'b0;
            out_fill   <= 1'b0;
            out_tag    <= '0;
        end else begin
            if (flush)        out_valid <= 1'b0;
            else if (advance) out_valid <= in_valid;
            if (advance && in_valid) begin
                out_data   <= shifted;
                out_amount <= in_amount;
                out_right  <= in_right;
                out_rot    <= in_rot;
                out_fill   <= in_fill;
                out_tag    <= in_tag;
            end
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter with valid/ready, tag sideband and flush.
// Define SHIFTER_ROTATE_EN to enable ROL/ROR.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STAGES    = 2,
    parameter int TAG_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [$clog2(WIDTH)-1:0]  in_amount,
    input  logic [SHIFT_OP_WIDTH-1:0] in_op,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [TAG_WIDTH-1:0]      out_tag
);

    localparam int L = $clog2(WIDTH);

    logic                 v     [STAGES+1];
    logic                 rdy   [STAGES+1];
    logic [WIDTH-1:0]     data  [STAGES+1];
    logic [L-1:0]         amt   [STAGES+1];
    logic                 right [STAGES+1];
    logic                 rot   [STAGES+1];
    logic                 fill  [STAGES+1];
    logic [TAG_WIDTH-1:0] tag   [STAGES+1];

    logic                 right0;
    logic                 rot0;
    logic                 fill0;
    logic                 pass0;
    logic [MAX_WIDTH-1:0] rev_in;
    logic [MAX_WIDTH-1:0] rev_out;
    logic                 unused_bits;

    always_comb begin
        right0 = 1'b0;
        rot0   = 1'b0;
        fill0  = 1'b0;
        pass0  = 1'b0;
        case (in_op)
            SHIFT_SLL: ;
            SHIFT_SRL: right0 = 1'b1;
            SHIFT_SRA: begin
                right0 = 1'b1;
                fill0  = in_data[WIDTH-1];
            end
`ifdef SHIFTER_ROTATE_EN
            SHIFT_ROL: rot0 = 1'b1;
            SHIFT_ROR: begin
                right0 = 1'b1;
                rot0   = 1'b1;
            end
`endif
            default:   pass0 = 1'b1;
        endcase
    end

    // Right shifts run as left shifts on the bit-reversed operand.
    assign rev_in  = bit_reverse(MAX_WIDTH'(in_data), WIDTH);
    assign rev_out = bit_reverse(MAX_WIDTH'(data[STAGES]), WIDTH);

    assign v[0]     = in_valid;
    assign data[0]  = right0 ? rev_in[WIDTH-1:0] : in_data;
    assign amt[0]   = pass0 ? '0 : in_amount;
    assign right[0] = right0;
    assign rot[0]   = rot0;
    assign fill[0]  = fill0;
    assign tag[0]   = in_tag;

    assign in_ready    = rdy[0] && !flush;
    assign rdy[STAGES] = out_ready;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int FIRST = (s * L + STAGES - 1) / STAGES;
        localparam int NEXT  = ((s + 1) * L + STAGES - 1) / STAGES;

        shifter_stage #(
            .WIDTH       (WIDTH),
            .FIRST_LEVEL (FIRST),
            .NUM_LEVELS  (NEXT - FIRST),
            .TAG_WIDTH   (TAG_WIDTH),
            .AMT_WIDTH   (L)
        ) u_stage (
            .clk        (clk),
            .reset_n    (reset_n),
            .flush      (flush),
            .in_valid   (v[s]),
            .in_ready   (rdy[s]),
            .in_data    (data[s]),
            .in_amount  (amt[s]),
            .in_right   (right[s]),
            .in_rot     (rot[s]),
            .in_fill    (fill[s]),
            .in_tag     (tag[s]),
            .out_valid  (v[s+1]),
            .out_ready  (rdy[s+1]),
            .out_data   (data[s+1]),
            .out_amount (amt[s+1]),
            .out_right  (right[s+1]),
            .out_rot    (rot[s+1]),
            .out_fill   (fill[s+1]),
            .out_tag    (tag[s+1])
        );
    end

    assign out_valid = v[STAGES];
    assign out_data  = right[STAGES] ? rev_out[WIDTH-1:0] : data[STAGES];
    assign out_tag   = tag[STAGES];

    assign unused_bits = ^{amt[STAGES], rot[STAGES], fill[STAGES],
                           rev_in, rev_out};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: directed vectors on a 32/2 instance,
// random traffic vs. an arithmetic model on 32/2 and 64/6 instances.
module tb_pipelined_shifter;

    localparam int W  = 32;
    localparam int S  = 2;
    localparam int TW = 5;
    localparam int WB = 64;
    localparam int SB = 6;
    localparam logic [3:0] PAT = 4'b1001;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] d;
        logic [4:0]  a;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  tag;
    } exp_t;

    int checks = 0;
    int errors = 0;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [4:0]    in_amount;
    logic [2:0]    in_op;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;

    logic          in_valid_b;
    logic          in_ready_b;
    logic [WB-1:0] in_data_b;
    logic [5:0]    in_amount_b;
    logic [2:0]    in_op_b;
    logic [TW-1:0] in_tag_b;
    logic          out_valid_b;
    logic          out_ready_b = 1'b1;
    logic [WB-1:0] out_data_b;
    logic [TW-1:0] out_tag_b;
    logic          flush_b = 1'b0;

    logic       hold_ready;
    logic       toggle_en;
    logic       sb_en;
    logic       sb_b_en;
    logic [1:0] phase = 2'd0;

    exp_t qa[$];
    exp_t qb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        phase <= phase + 2'd1;
        out_ready_b <= ($urandom_range(0, 3) != 0);
    end

    assign out_ready = toggle_en ? PAT[phase] : hold_ready;

    pipelined_shifter #(.WIDTH(W), .STAGES(S), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amount(in_amount),
        .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    pipelined_shifter #(.WIDTH(WB), .STAGES(SB), .TAG_WIDTH(TW)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .in_amount(in_amount_b),
        .in_op(in_op_b), .in_tag(in_tag_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .out_tag(out_tag_b)
    );

    function automatic void check(string nm, logic [63:0] act,
                                  logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    // Plain arithmetic reference over a w-bit word.
    function automatic logic [63:0] ref_shift(int w, logic [2:0] op,
                                              logic [63:0] din, int a);
        logic [63:0] m;
        logic [63:0] d;
        logic [63:0] r;
        m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        d = din & m;
        case (op)
            3'b000: r = (d << a) & m;
            3'b001: r = d >> a;
            3'b011: begin
                r = d >> a;
                if (d[w-1]) r = r | (m & ~(m >> a));
            end
`ifdef SHIFTER_ROTATE_EN
            3'b100: r = ((d << a) | (d >> (w - a))) & m;
            3'b101: r = ((d >> a) | (d << (w - a))) & m;
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (sb_en) begin
            check("in_ready_a", in_ready, !(qa.size() == S && !out_ready));
            if (out_valid) begin
                if (qa.size() == 0) check("spurious_a", 1, 0);
                else begin
                    check("data_a", out_data, qa[0].data);
                    check("tag_a", out_tag, qa[0].tag);
                    if (out_ready) void'(qa.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (sb_b_en) begin
            check("in_ready_b", in_ready_b,
                  !(qb.size() == SB && !out_ready_b));
            if (out_valid_b) begin
                if (qb.size() == 0) check("spurious_b", 1, 0);
                else begin
                    check("data_b", out_data_b, qb[0].data);
                    check("tag_b", out_tag_b, qb[0].tag);
                    if (out_ready_b) void'(qb.pop_front());
                end
            end
        end
    end

    task automatic push_a(logic [2:0] op, logic [31:0] d, logic [4:0] a,
                          logic [4:0] t);
        bit acc = 0;
        int guard = 0;
        in_valid = 1; in_op = op; in_data = d; in_amount = a; in_tag = t;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) qa.push_back('{ref_shift(W, op, 64'(d), int'(a)), 8'(t)});
            #1;
            guard++;
            if (!acc && guard > 50) begin
                check("accept_timeout_a", 0, 1);
                acc = 1;
            end
        end
        in_valid = 0;
    endtask

    task automatic push_b(logic [2:0] op, logic [63:0] d, logic [5:0] a,
                          logic [4:0] t);
        bit acc = 0;
        int guard = 0;
        in_valid_b = 1; in_op_b = op; in_data_b = d;
        in_amount_b = a; in_tag_b = t;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready_b;
            @(posedge clk);
            if (acc) qb.push_back('{ref_shift(WB, op, d, int'(a)), 8'(t)});
            #1;
            guard++;
            if (!acc && guard > 50) begin
                check("accept_timeout_b", 0, 1);
                acc = 1;
            end
        end
        in_valid_b = 0;
    endtask

    task automatic run_one(string nm, logic [2:0] op, logic [31:0] d,
                           logic [4:0] a, logic [4:0] t, logic [31:0] exp);
        int n = 0;
        in_valid = 1; in_op = op; in_data = d; in_amount = a; in_tag = t;
        @(negedge clk);
        check({nm, "_ready"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        check({nm, "_latency"}, n, S);
        check({nm, "_data"}, out_data, exp);
        check({nm, "_tag"}, out_tag, t);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(string nm, int cycles);
        bit seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check(nm, seen, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int g = 0;
        while ((qa.size() != 0 || qb.size() != 0) && g < 300) begin
            @(posedge clk);
            g++;
        end
        check("drain", qa.size() + qb.size(), 0);
        #1;
    endtask

    initial begin
        reset_n = 0; flush = 0;
        in_valid = 0; in_data = '0; in_amount = '0; in_op = '0; in_tag = '0;
        in_valid_b = 0; in_data_b = '0; in_amount_b = '0;
        in_op_b = '0; in_tag_b = '0;
        hold_ready = 1; toggle_en = 0; sb_en = 0; sb_b_en = 0;

        vecs.push_back('{3'b000, 32'h0000_0001, 5'd31, 32'h8000_0000});
        vecs.push_back('{3'b011, 32'h8000_0000, 5'd4,  32'hF800_0000});
        vecs.push_back('{3'b001, 32'h8000_0000, 5'd4,  32'h0800_0000});
        vecs.push_back('{3'b011, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF});
        vecs.push_back('{3'b011, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF});
        vecs.push_back('{3'b001, 32'hF000_0000, 5'd31, 32'h0000_0001});
        vecs.push_back('{3'b000, 32'h0000_FFFF, 5'd16, 32'hFFFF_0000});
        vecs.push_back('{3'b000, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5});
        vecs.push_back('{3'b011, 32'h8000_0000, 5'd0,  32'h8000_0000});
        vecs.push_back('{3'b010, 32'h1234_5678, 5'd7,  32'h1234_5678});
        vecs.push_back('{3'b111, 32'hDEAD_BEEF, 5'd31, 32'hDEAD_BEEF});
`ifdef SHIFTER_ROTATE_EN
        vecs.push_back('{3'b101, 32'h0000_00F1, 5'd4,  32'h1000_000F});
        vecs.push_back('{3'b100, 32'h8000_0001, 5'd1,  32'h0000_0003});
`else
        vecs.push_back('{3'b101, 32'h0000_00F1, 5'd4,  32'h0000_00F1});
        vecs.push_back('{3'b100, 32'h8000_0001, 5'd1,  32'h8000_0001});
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_tag", out_tag, 0);
        check("reset_valid_b", out_valid_b, 0);
        @(posedge clk);
        #1 reset_n = 1;
        sb_b_en = 1;

        run_one("vec0", 3'b000, 32'h1, 5'd31, 5'h0A, 32'h8000_0000);
        for (int i = 0; i < vecs.size(); i++)
            run_one($sformatf("vec%0d", i + 1), vecs[i].op, vecs[i].d,
                    vecs[i].a, 5'(i + 1), vecs[i].exp);

        // Back-to-back under a 1,0,0,1 out_ready pattern.
        sb_en = 1; toggle_en = 1;
        for (int i = 0; i < 8; i++)
            push_a(3'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 31)), 5'(i));
        drain();
        toggle_en = 0;

        // Flush with two ops in flight and a third offered.
        sb_en = 0;
        in_valid = 1; in_op = 3'b000; in_data = 32'h11; in_amount = 5'd1;
        in_tag = 5'd1;
        @(posedge clk);
        #1 in_tag = 5'd2;
        @(posedge clk);
        #1 in_tag = 5'd3; flush = 1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1 flush = 0; in_valid = 0;
        quiet("flush_quiet", 4);
        run_one("post_flush", 3'b001, 32'h0000_0100, 5'd8, 5'd4, 32'h1);

        // Reset with two ops in flight.
        in_valid = 1; in_op = 3'b000; in_data = 32'h5; in_amount = 5'd2;
        in_tag = 5'd5;
        @(posedge clk);
        #1 in_tag = 5'd6;
        @(posedge clk);
        #1 in_valid = 0; reset_n = 0;
        @(posedge clk);
        #1 reset_n = 1;
        @(negedge clk);
        check("midreset_valid", out_valid, 0);
        check("midreset_data", out_data, 0);
        check("midreset_tag", out_tag, 0);
        @(posedge clk);
        #1;
        quiet("midreset_quiet", 3);
        run_one("post_reset", 3'b011, 32'hF000_0000, 5'd28, 5'd7,
                32'hFFFF_FFFF);

        // Random traffic on the narrow instance with random stalls.
        sb_en = 1; toggle_en = 1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            push_a(3'($urandom_range(0, 7)), $urandom,
                   ($urandom_range(0, 7) == 0) ? 5'd0
                                               : 5'($urandom_range(0, 31)),
                   5'(i));
        end
        drain();
        toggle_en = 0;

        // Wide instance: directed passthroughs then random ops.
        for (int op = 0; op < 8; op++)
            push_b(3'(op), {$urandom, $urandom}, 6'd0, 5'(op));
        push_b(3'b111, 64'hFEDC_BA98_7654_3210, 6'd37, 5'd9);
        push_b(3'b011, 64'h8000_0000_0000_0000, 6'd63, 5'd10);
        for (int i = 0; i < 200; i++)
            push_b(3'($urandom_range(0, 7)), {$urandom, $urandom},
                   ($urandom_range(0, 7) == 0) ? 6'd0
                                               : 6'($urandom_range(0, 63)),
                   5'(i));
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
